// File: rtl/mac_sequencer.sv
// Operand buffer and sequencer for the 2-bit MAC: streams buffered pairs into the MAC on start,
// then captures the accumulated dot product and presents it on a valid/ready result port.
module mac_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [1:0]        i_wr_a,
  input  logic [1:0]        i_wr_b,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_start,
  output logic              o_busy,
  output logic [1:0]        o_mac_a,
  output logic [1:0]        o_mac_b,
  output logic              o_mac_en,
  output logic              o_mac_clr,
  input  logic [7:0]        i_mac_out,
  output logic [7:0]        o_result,
  output logic              o_result_valid,
  input  logic              i_result_ready
);

  // state   | meaning
  // IDLE    | accepting buffer writes and start
  // CLEAR   | one-cycle MAC accumulator clear
  // RUN     | one operand pair per cycle, eff_len cycles
  // CAPTURE | MAC holds final sum; latch it into result
  // DONE    | result offered until the valid/ready handshake
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [3:0]        r_buf [DEPTH];
  logic [ADDR_W:0]   r_left, w_left_nxt, w_len_clamped;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [3:0]        w_rd;
  logic              w_wr_in_range;

  logic              r_busy, r_mac_en, r_mac_clr, r_result_valid;
  logic [1:0]        r_mac_a, r_mac_b;
  logic [7:0]        r_result;

  generate
    if ((1 << ADDR_W) == DEPTH) begin : g_pow2
      assign w_wr_in_range = 1'b1;
    end else begin : g_npow2
      assign w_wr_in_range = (32'(i_wr_addr) < DEPTH);
    end
  endgenerate

  assign w_len_clamped = (i_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_len;

  // r_left counts the RUN cycles still owed, including the current one
  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_left;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_CLEAR;
          w_left_nxt  = w_len_clamped;
        end
      end
      S_CLEAR: begin
        w_idx_nxt   = '0;
        w_state_nxt = (r_left != '0) ? S_RUN : S_CAPTURE;
      end
      S_RUN: begin
        w_left_nxt = r_left - 1'b1;
        w_idx_nxt  = r_idx + 1'b1;
        if (r_left == (ADDR_W+1)'(1)) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_DONE;
      S_DONE: begin
        if (i_result_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are fetched for the next state so the MAC outputs can be registered
  assign w_rd = (w_state_nxt == S_RUN) ? r_buf[w_idx_nxt] : 4'd0;

  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_wr_en && w_wr_in_range)
      r_buf[i_wr_addr] <= {i_wr_a, i_wr_b};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_left         <= '0;
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_mac_en       <= 1'b0;
      r_mac_clr      <= 1'b0;
      r_mac_a        <= 2'd0;
      r_mac_b        <= 2'd0;
      r_result       <= 8'd0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_left         <= w_left_nxt;
      r_idx          <= w_idx_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_mac_en       <= (w_state_nxt == S_RUN);
      r_mac_clr      <= (w_state_nxt == S_CLEAR);
      r_mac_a        <= w_rd[3:2];
      r_mac_b        <= w_rd[1:0];
      r_result_valid <= (w_state_nxt == S_DONE);
      if (r_state == S_CAPTURE) r_result <= i_mac_out;
    end
  end

  assign o_busy         = r_busy;
  assign o_mac_a        = r_mac_a;
  assign o_mac_b        = r_mac_b;
  assign o_mac_en       = r_mac_en;
  assign o_mac_clr      = r_mac_clr;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

endmodule
